// File: rtl/demux_dispatch.sv
// demux_dispatch: fans one valid/ready word stream out to LANES one-entry lane registers,
// steering each word by explicit select (mode 0) or by a strict round-robin pointer (mode 1).
module demux_dispatch #(
   parameter int WIDTH = 16,
   parameter int LANES = 4,
   parameter int SEL_W = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   mode,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       in_data,
   input  logic [SEL_W-1:0]       in_sel,
   output logic [LANES-1:0]       out_valid,
   input  logic [LANES-1:0]       out_ready,
   output logic [LANES*WIDTH-1:0] out_data,
   output logic [SEL_W-1:0]       rr_ptr,
   output logic [15:0]            xfer_count
);

   logic [LANES-1:0]       valid_q, valid_d;
   logic [LANES*WIDTH-1:0] data_q, data_d;
   logic [SEL_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [15:0]            xfer_count_q, xfer_count_d;
   logic [SEL_W-1:0]       target_s;
   logic                   accept_s;

   // Target lane and input handshake; a lane draining this cycle can take a new word.
   always_comb begin
      if (mode) begin
         target_s = rr_ptr_q;
      end else begin
         target_s = in_sel;
      end
      in_ready = !valid_q[target_s] || out_ready[target_s];
      accept_s = in_valid && in_ready;
   end

   // Per-lane next state: a load wins over a drain, data is kept after a drain.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      for (int i = 0; i < LANES; i++) begin
         if (accept_s && (target_s == SEL_W'(i))) begin
            valid_d[i]               = 1'b1;
            data_d[i*WIDTH +: WIDTH] = in_data;
         end else if (valid_q[i] && out_ready[i]) begin
            valid_d[i] = 1'b0;
         end else begin
            valid_d[i] = valid_q[i];
         end
      end
   end

   // Round-robin pointer advances only on accepts made in round-robin mode.
   always_comb begin
      if (accept_s) begin
         xfer_count_d = xfer_count_q + 16'd1;
         if (mode) begin
            rr_ptr_d = rr_ptr_q + SEL_W'(1);
         end else begin
            rr_ptr_d = rr_ptr_q;
         end
      end else begin
         xfer_count_d = xfer_count_q;
         rr_ptr_d     = rr_ptr_q;
      end
   end

   // State registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q      <= {LANES{1'b0}};
         data_q       <= {(LANES*WIDTH){1'b0}};
         rr_ptr_q     <= {SEL_W{1'b0}};
         xfer_count_q <= 16'd0;
      end else begin
         valid_q      <= valid_d;
         data_q       <= data_d;
         rr_ptr_q     <= rr_ptr_d;
         xfer_count_q <= xfer_count_d;
      end
   end

   assign out_valid  = valid_q;
   assign out_data   = data_q;
   assign rr_ptr     = rr_ptr_q;
   assign xfer_count = xfer_count_q;

endmodule

// File: doc/demux_dispatch.md
Name: demux_dispatch

Overview:
- Demultiplexing counterpart of the word-mux path: one input word stream fans out to LANES output lanes.
- The destination lane is chosen by an explicit select or by an internal round-robin pointer.
- Each lane has a one-entry holding register with a valid/ready handshake.
- Sits between a single producer (e.g. the CPU write path) and LANES independent consumers (register/RAM banks, peripherals).

Parameters:
- WIDTH, 16, data word width in bits (Hack word size).
- LANES, 4, number of output lanes; must be a power of two, at least 2.
- SEL_W, 2, select width; must equal log2(LANES).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- mode  input  1  0 = directed (lane = in_sel), 1 = round-robin (lane = rr_ptr)
- in_valid  input  1  producer presents a word
- in_ready  output  1  block accepts the word this cycle
- in_data  input  WIDTH  input word
- in_sel  input  SEL_W  destination lane in directed mode; ignored in round-robin mode
- out_valid  output  LANES  bit i: lane i holds a word
- out_ready  input  LANES  bit i: consumer i takes lane i's word this cycle
- out_data  output  LANES*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH]
- rr_ptr  output  SEL_W  next round-robin lane
- xfer_count  output  16  number of accepted input words, wrapping

Behaviour:
- Reset (asynchronous, active-high), immediate on assertion:
  - out_valid = 0, all out_data = 0, rr_ptr = 0, xfer_count = 0.
  - Words held at reset time are discarded.
  - in_ready follows the combinational rule below and is 1 during reset.
- target = mode ? rr_ptr : in_sel. This is combinational and sampled in the same cycle as the handshake.
- in_ready = !out_valid[target] || out_ready[target].
  - in_ready is combinational from mode, in_sel, rr_ptr, out_valid and out_ready.
  - It does not depend on in_valid.
- Accept occurs when in_valid && in_ready at a rising clk edge. On accept:
  - out_data[target] <= in_data and out_valid[target] <= 1.
  - xfer_count <= xfer_count + 1, modulo 2^16 (0xFFFF wraps to 0x0000).
  - In mode 1: rr_ptr <= (rr_ptr + 1) mod LANES. In mode 0: rr_ptr is unchanged.
- Latency: a word accepted at edge N is visible on out_valid/out_data after edge N. There is no combinational bypass from in_data to out_data.
- Drain: when out_valid[i] && out_ready[i] at an edge and lane i is not loaded that edge, out_valid[i] <= 0. out_data[i] keeps its last value (it is not cleared).
- Simultaneous drain and load on the same lane (full lane, out_ready[i] = 1, accepting):
  - Old word leaves, new word is stored.
  - out_valid[i] stays 1.
  - No bubble, no loss.
- Non-target lanes:
  - Drain independently in the same cycle.
  - Their data and valid are unaffected by the input transfer.
- Round-robin is strict order:
  - If the rr_ptr lane is full and not draining, in_ready = 0 and the block stalls.
  - It never skips to a free lane.
- Mode may change on any cycle. It takes effect immediately on target, and rr_ptr keeps its value across mode changes.
- in_valid = 0: no state change except drains. in_data and in_sel are don't-care.
- Full/empty boundaries:
  - All lanes full with no out_ready: in_ready = 0 in both modes.
  - All lanes empty: in_ready = 1 for any target.
- Output word ordering per lane is FIFO of depth 1. Words are never duplicated or reordered within a lane.

Test Plan:
- Reset then directed fill:
  - Stimulus: after reset, mode = 0 with in_sel = 2, in_data = 0x1234, in_valid = 1 for 1 cycle.
  - Required: out_valid = 4'b0100, lane 2 data = 0x1234, xfer_count = 1, rr_ptr = 0.
- Back-pressure:
  - Stimulus: lane 2 full with out_ready = 0, present in_sel = 2.
  - Required: in_ready = 0, lane 2 data stays 0x1234, xfer_count unchanged.
  - Then raise out_ready[2] with in_data = 0xBEEF. Required: accepted the same cycle, out_valid[2] stays 1, data = 0xBEEF.
- Round-robin sweep:
  - Stimulus: mode = 1, five words 0xA0..0xA4 while all out_ready = 1.
  - Required: lanes 0,1,2,3,0 receive 0xA0, 0xA1, 0xA2, 0xA3, 0xA4; rr_ptr ends at 1; xfer_count = 5.
- Strict round-robin stall:
  - Stimulus: mode = 1, rr_ptr = 1, lane 1 full, lanes 0/2/3 empty, out_ready = 0.
  - Required: in_ready = 0 and no lane changes.
  - Then switch to mode = 0 with in_sel = 3. Required: word lands in lane 3 and rr_ptr stays 1.
- Counter wrap:
  - Stimulus: accept 65,536 words.
  - Required: xfer_count returns to 0x0000 and then reads 0x0001 after one more accept.
- Reset mid-operation:
  - Stimulus: with out_valid = 4'b1011 and rr_ptr = 3, assert reset between clock edges.
  - Required: out_valid = 0, all out_data = 0, rr_ptr = 0, xfer_count = 0 immediately, without waiting for clk.
